// File: rtl/axi_fetch_unit.sv
// axi_fetch_unit: instruction fetch stage.
//   Takes one PC from next-PC logic, issues a single-beat AXI4 read and hands
//   the selected 32-bit instruction (with PC and fault flag) to decode.
//   Only one fetch is outstanding at a time. RESET_PC is fetched right after reset.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   pc_i/pc_valid_i/pc_ready_o   next-PC handshake
//   inst_o/inst_pc_o/inst_fault_o/inst_valid_o/inst_ready_i  decode handshake
//   ar*/r*                       AXI4 read address / read data channels
// Optional feature (macro AXI_FETCH_PERF_EN):
//   perf_fetch_cnt_o  count of completed decode handshakes
//   perf_stall_cnt_o  count of cycles spent in AR or R
module axi_fetch_unit #(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] araddr,
  output logic        arvalid,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic        rvalid,
  input  logic [1:0]  rresp,
  input  logic [3:0]  rid,
  input  logic        rlast,
  output logic        rready
`ifdef AXI_FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt_o,
  output logic [63:0] perf_stall_cnt_o
`endif
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                boot_q, boot_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                pc_ready_q, pc_ready_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                inst_fault_q, inst_fault_d;
  logic                inst_valid_q, inst_valid_d;

  // OKAY vs EXOKAY is irrelevant here; only the error bit matters.
  logic unused_rresp;
  assign unused_rresp = rresp[0];

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    boot_d       = 1'b0;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    case (state_q)
      IDLE: begin
        if (boot_q) begin
          // First cycle out of reset fetches the reset vector unprompted.
          state_d  = AR;
          pc_d     = RESET_PC;
          araddr_d = RESET_PC;
        end else if (pc_valid_i && pc_ready_q) begin
          pc_d = pc_i;
          if (pc_i[1:0] != 2'b00) begin
            // Misaligned PC faults locally without touching the bus.
            state_d      = OUT;
            inst_d       = '0;
            inst_pc_d    = pc_i;
            inst_fault_d = 1'b1;
          end else begin
            state_d  = AR;
            araddr_d = pc_i;
          end
        end
      end
      AR: begin
        if (arvalid_q && arready) begin
          state_d = R;
        end
      end
      R: begin
        if (rready_q && rvalid) begin
          inst_d       = pc_q[2] ? rdata[63:32] : rdata[31:0];
          inst_pc_d    = pc_q;
          inst_fault_d = rresp[1] | (rid != AXI_ID) | ~rlast;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (inst_valid_q && inst_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are a registered decode of the next state.
    arvalid_d    = (state_d == AR);
    rready_d     = (state_d == R);
    inst_valid_d = (state_d == OUT);
    pc_ready_d   = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      boot_q       <= 1'b1;
      pc_q         <= '0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      pc_ready_q   <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_q       <= boot_d;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      pc_ready_q   <= pc_ready_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign pc_ready_o   = pc_ready_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_fault_o = inst_fault_q;
  assign inst_valid_o = inst_valid_q;
  assign araddr       = araddr_q;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;

  // Single-beat, 4-byte, INCR read with a fixed ID.
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

`ifdef AXI_FETCH_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Performance counters; both wrap naturally at 2^64.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == OUT && inst_valid_q && inst_ready_i) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
    if (state_q == AR || state_q == R) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_fetch_unit.sv
// Testbench for axi_fetch_unit: directed stimulus with an expected-response
// queue checked by an independent monitor on each decode handshake.
module tb_axi_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_fault_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 1'b1;
  logic [63:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic [1:0]  rresp = '0;
  logic [3:0]  rid = '0;
  logic        rlast = 1'b0;
  logic        rready;
`ifdef AXI_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt_o;
  logic [63:0] perf_stall_cnt_o;
`endif

  axi_fetch_unit dut (
    .clock(clock), .reset(reset),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rresp(rresp), .rid(rid),
    .rlast(rlast), .rready(rready)
`ifdef AXI_FETCH_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Stimulus samples and drives 2 time units after the rising edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Monitor: every decode handshake must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inst", {32'd0, inst_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("inst_o", 64'(inst_o), 64'(e.inst));
        chk("inst_pc_o", 64'(inst_pc_o), 64'(e.pc));
        chk("inst_fault_o", 64'(inst_fault_o), 64'(e.fault));
      end
    end
  end

  task automatic send_pc(input logic [31:0] pc);
    int n = 0;
    while (!pc_ready_o && n < 20) begin step(); n++; end
    chk("pc_ready_wait", 64'(pc_ready_o), 64'd1);
    pc_valid_i = 1'b1;
    pc_i       = pc;
    step();
    pc_valid_i = 1'b0;
  endtask

  // AXI slave: hold arready low for ar_delay cycles, then respond one beat.
  task automatic axi_serve(input int ar_delay, input logic [63:0] d,
                           input logic [1:0] resp, input logic [3:0] id,
                           input logic l, input logic [31:0] exp_addr);
    int n = 0;
    while (!arvalid && n < 20) begin step(); n++; end
    chk("arvalid_seen", 64'(arvalid), 64'd1);
    chk("araddr", 64'(araddr), 64'(exp_addr));
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      step();
      chk("arvalid_hold", 64'(arvalid), 64'd1);
      chk("araddr_hold", 64'(araddr), 64'(exp_addr));
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("ar_single_handshake", {62'd0, arvalid, rready}, 64'd1);
    rvalid = 1'b1; rdata = d; rresp = resp; rid = id; rlast = l;
    step();
    rvalid = 1'b0; rdata = '0; rlast = 1'b0;
    chk("rready_drop", 64'(rready), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic        seen_ar;
    logic [31:0] held_inst;

    // Reset values.
    repeat (3) step();
    chk("rst_pc_ready", 64'(pc_ready_o), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_fault", 64'(inst_fault_o), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);

    // Boot fetch of the reset vector.
    exp_q.push_back('{inst: 32'h0010_0073, pc: 32'h3000_0000, fault: 1'b0});
    reset = 1'b0;
    step();
    chk("boot_arvalid", 64'(arvalid), 64'd1);
    chk("ar_const", {49'd0, arid, arlen, arsize, arburst}, {49'd0, 4'd0, 8'd0, 3'b010, 2'b01});
    axi_serve(0, 64'h1111_2222_0010_0073, 2'b00, 4'd0, 1'b1, 32'h3000_0000);
    drain();

    // Upper word select, with minimum-latency check.
    exp_q.push_back('{inst: 32'hDEAD_BEEF, pc: 32'h3000_0004, fault: 1'b0});
    send_pc(32'h3000_0004);
    chk("min_lat_arvalid", 64'(arvalid), 64'd1);
    axi_serve(0, 64'hDEAD_BEEF_0000_0000, 2'b00, 4'd0, 1'b1, 32'h3000_0004);
    drain();

    // arready stalled for 5 cycles.
    exp_q.push_back('{inst: 32'h1234_5678, pc: 32'h3000_0008, fault: 1'b0});
    send_pc(32'h3000_0008);
    axi_serve(5, 64'hAAAA_BBBB_1234_5678, 2'b00, 4'd0, 1'b1, 32'h3000_0008);
    drain();

    // Error response, wrong ID, missing rlast, and EXOKAY (not a fault).
    exp_q.push_back('{inst: 32'h0BAD_F00D, pc: 32'h3000_000C, fault: 1'b1});
    send_pc(32'h3000_000C);
    axi_serve(0, 64'h0BAD_F00D_0000_0000, 2'b10, 4'd0, 1'b1, 32'h3000_000C);
    drain();
    exp_q.push_back('{inst: 32'h0000_0013, pc: 32'h3000_0010, fault: 1'b1});
    send_pc(32'h3000_0010);
    axi_serve(1, 64'h5555_5555_0000_0013, 2'b00, 4'd3, 1'b1, 32'h3000_0010);
    drain();
    exp_q.push_back('{inst: 32'h0000_0093, pc: 32'h3000_0014, fault: 1'b1});
    send_pc(32'h3000_0014);
    axi_serve(0, 64'h0000_0093_7777_7777, 2'b00, 4'd0, 1'b0, 32'h3000_0014);
    drain();
    exp_q.push_back('{inst: 32'h0000_0113, pc: 32'h3000_0018, fault: 1'b0});
    send_pc(32'h3000_0018);
    axi_serve(0, 64'h9999_9999_0000_0113, 2'b01, 4'd0, 1'b1, 32'h3000_0018);
    drain();

    // Misaligned PC: local fault, no AR ever.
    exp_q.push_back('{inst: 32'h0000_0000, pc: 32'h3000_0002, fault: 1'b1});
    seen_ar = 1'b0;
    send_pc(32'h3000_0002);
    for (int i = 0; i < 4; i++) begin
      seen_ar |= arvalid;
      step();
    end
    chk("misalign_no_ar", 64'(seen_ar), 64'd0);
    drain();

    // Decode stalls 4 cycles; a PC pulse meanwhile must be ignored.
    inst_ready_i = 1'b0;
    exp_q.push_back('{inst: 32'hCAFE_0001, pc: 32'h3000_0020, fault: 1'b0});
    send_pc(32'h3000_0020);
    axi_serve(0, 64'h0000_0000_CAFE_0001, 2'b00, 4'd0, 1'b1, 32'h3000_0020);
    held_inst = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 64'(inst_valid_o), 64'd1);
      chk("stall_pc_ready", 64'(pc_ready_o), 64'd0);
      chk("stall_inst_hold", 64'(inst_o), 64'(held_inst));
      pc_valid_i = (i == 1);
      pc_i       = 32'h3000_0100;
      step();
    end
    pc_valid_i   = 1'b0;
    inst_ready_i = 1'b1;
    drain();
    seen_ar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen_ar |= arvalid;
      step();
    end
    chk("stall_pulse_ignored", 64'(seen_ar), 64'd0);

    // Reset while waiting in R.
    send_pc(32'h3000_0040);
    begin
      int n = 0;
      while (!arvalid && n < 20) begin step(); n++; end
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("pre_reset_rready", 64'(rready), 64'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_inst_valid", 64'(inst_valid_o), 64'd0);
    step();
    exp_q.push_back('{inst: 32'h0000_0073, pc: 32'h3000_0000, fault: 1'b0});
    reset = 1'b0;
    axi_serve(0, 64'h0000_0000_0000_0073, 2'b00, 4'd0, 1'b1, 32'h3000_0000);
    drain();

    repeat (2) step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
